spi_reg_sequencer: RTL and testbench

SPI_REG_SEQUENCER -- requirements
Module: spi_reg_sequencer

---
 rtl/spi_reg_sequencer_if.sv | 28 ++
 rtl/spi_reg_sequencer.sv | 106 ++++++++++
 tb/tb_spi_reg_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_sequencer_if.sv
// spi_reg_sequencer_if: byte stream in, register write buffer and read-mux strobe out
// Ports (master = sequencer side):
//   byte_valid/byte_data/frame_end : received SPI bytes and end-of-frame pulse
//   wr_valid/wr_addr/wr_data/wr_ready : write-buffer head handshake to the register file
//   rd_addr/rd_strobe : POCI mux select and shift-register load pulse
//   busy/err/err_clr : activity flag, sticky error and its clear
interface spi_reg_sequencer_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_end;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [7:0] rd_addr;
   logic       rd_strobe;
   logic       busy;
   logic       err;
   logic       err_clr;
   modport master (
      input  byte_valid, byte_data, frame_end, wr_ready, err_clr,
      output wr_valid, wr_addr, wr_data, rd_addr, rd_strobe, busy, err
   );
   modport slave (
      output byte_valid, byte_data, frame_end, wr_ready, err_clr,
      input  wr_valid, wr_addr, wr_data, rd_addr, rd_strobe, busy, err
   );
endinterface

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: decodes SPI address/data bytes into buffered register writes and read strobes
// Ports:
//   sclk : clock, all state on its rising edge
//   rstn : asynchronous active-low reset
//   bus  : spi_reg_sequencer_if.master (byte input, write-buffer head, read select, busy/err)
module spi_reg_sequencer #(
   parameter int NUM_REGS   = 64,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input logic                 sclk,
   input logic                 rstn,
   spi_reg_sequencer_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH = FIFO_DEPTH;
   typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} state_t;
   state_t        state;
   logic [6:0]    ptr;
   logic [6:0]    ptr_inc;
   logic [4:0]    cnt;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   used;
   logic          pop;
   logic          full;
   logic          at_limit;
   logic          accept;
   assign ptr_inc = (ptr == 7'(NUM_REGS - 1)) ? 7'd0 : ptr + 7'd1;
   assign pop = bus.wr_valid && bus.wr_ready;
   assign full = used == DEPTH;
   assign at_limit = cnt == 5'(MAX_BURST);
   // a full buffer still takes the byte when the head leaves in the same cycle
   assign accept = bus.byte_valid && state == WRITE && !at_limit && (!full || pop);
   assign bus.wr_valid = used != '0;
   assign {bus.wr_addr, bus.wr_data} = mem[head];
   assign bus.busy = state != IDLE || bus.wr_valid;
   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         ptr           <= '0;
         cnt           <= '0;
         head          <= '0;
         tail          <= '0;
         used          <= '0;
         bus.rd_addr   <= '0;
         bus.rd_strobe <= 1'b0;
         bus.err       <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         bus.rd_strobe <= 1'b0;
         if (bus.err_clr) bus.err <= 1'b0;
         if (accept) begin
            mem[tail] <= {1'b0, ptr, bus.byte_data};
            tail      <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         used <= used + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
         if (bus.byte_valid) begin
            case (state)
               IDLE: if (!bus.frame_end) begin
                  if ({1'b0, bus.byte_data[6:0]} >= 8'(NUM_REGS)) begin
                     state   <= DISCARD;
                     bus.err <= 1'b1;
                  end else begin
                     ptr   <= bus.byte_data[6:0];
                     cnt   <= '0;
                     state <= bus.byte_data[7] ? READ : WRITE;
                     if (bus.byte_data[7]) begin
                        bus.rd_addr   <= {1'b0, bus.byte_data[6:0]};
                        bus.rd_strobe <= 1'b1;
                     end
                  end
               end
               WRITE: if (at_limit) begin
                  state   <= DISCARD;
                  bus.err <= 1'b1;
               end else begin
                  // an overflowed byte is lost but still consumes an address slot
                  ptr <= ptr_inc;
                  cnt <= cnt + 5'd1;
                  if (!accept) bus.err <= 1'b1;
               end
               READ: if (at_limit) begin
                  state   <= DISCARD;
                  bus.err <= 1'b1;
               end else begin
                  ptr <= ptr_inc;
                  cnt <= cnt + 5'd1;
                  // the strobe would land in IDLE when the frame ends on this byte
                  if (!bus.frame_end) begin
                     bus.rd_addr   <= {1'b0, ptr_inc};
                     bus.rd_strobe <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (bus.frame_end) begin
            state <= IDLE;
            cnt   <= '0;
         end
      end
   end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb_spi_reg_sequencer: scoreboard bench for spi_reg_sequencer
module tb_spi_reg_sequencer;
   logic        sclk = 1'b0;
   logic        rstn = 1'b0;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic [15:0] e_wr;
   logic [7:0]  e_rd;
   spi_reg_sequencer_if bus();
   spi_reg_sequencer #(.NUM_REGS(64), .MAX_BURST(16), .FIFO_DEPTH(4)) dut (
      .sclk(sclk),
      .rstn(rstn),
      .bus (bus)
   );
   always #5 sclk = ~sclk;
   // outputs sampled mid-cycle: a visible handshake completes on the next rising edge
   always @(negedge sclk) begin
      if (rstn && bus.wr_valid && bus.wr_ready) begin
         checks++;
         if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write got=%h_%h want=none", bus.wr_addr, bus.wr_data);
         end else begin
            e_wr = exp_wr.pop_front();
            if ({bus.wr_addr, bus.wr_data} !== e_wr) begin
               failures++;
               $display("FAIL write got=%h_%h want=%h_%h", bus.wr_addr, bus.wr_data, e_wr[15:8], e_wr[7:0]);
            end
         end
      end
      if (rstn && bus.rd_strobe) begin
         checks++;
         if (exp_rd.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe got=%h want=none", bus.rd_addr);
         end else begin
            e_rd = exp_rd.pop_front();
            if (bus.rd_addr !== e_rd) begin
               failures++;
               $display("FAIL rd_addr got=%h want=%h", bus.rd_addr, e_rd);
            end
         end
      end
   end
   task automatic pulse(input logic [7:0] b, input logic bv = 1'b1, input logic fe = 1'b0, input logic ec = 1'b0);
      bus.byte_valid = bv;
      bus.byte_data  = b;
      bus.frame_end  = fe;
      bus.err_clr    = ec;
      @(posedge sclk); #1;
      bus.byte_valid = 1'b0;
      bus.frame_end  = 1'b0;
      bus.err_clr    = 1'b0;
      @(posedge sclk); #1;
   endtask
   task automatic wait_idle;
      int n = 0;
      while (bus.busy && n < 100) begin
         @(posedge sclk); #1;
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_timeout got=%b want=0", bus.busy);
      end
   endtask
   task automatic test_reset;
      rstn = 1'b0;
      #12;
      checks++;
      if ({bus.wr_valid, bus.wr_addr, bus.wr_data, bus.rd_addr, bus.rd_strobe, bus.busy, bus.err} !== 28'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%b%h%h%h%b%b%b want=all_zero", bus.wr_valid, bus.wr_addr, bus.wr_data,
                  bus.rd_addr, bus.rd_strobe, bus.busy, bus.err);
      end
      @(posedge sclk); #1;
      rstn = 1'b1;
      @(posedge sclk); #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b want=0", bus.busy);
      end
   endtask
   task automatic test_write_burst;
      bus.wr_ready = 1'b1;
      exp_wr.push_back(16'h05AA);
      exp_wr.push_back(16'h06BB);
      pulse(8'h05);
      pulse(8'hAA);
      pulse(8'hBB);
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle();
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL write_burst_pending got=%0d want=0", exp_wr.size());
      end
   endtask
   task automatic test_read;
      exp_rd.push_back(8'h0A);
      exp_rd.push_back(8'h0B);
      exp_rd.push_back(8'h0C);
      pulse(8'h8A);
      pulse(8'h00);
      pulse(8'h00);
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle();
      checks++;
      if (exp_rd.size() != 0) begin
         failures++;
         $display("FAIL read_pending got=%0d want=0", exp_rd.size());
      end
      checks++;
      if (bus.rd_addr !== 8'h0C) begin
         failures++;
         $display("FAIL read_final_addr got=%h want=0c", bus.rd_addr);
      end
   endtask
   task automatic test_wrap;
      exp_wr.push_back(16'h3F11);
      exp_wr.push_back(16'h0022);
      pulse(8'h3F);
      pulse(8'h11);
      pulse(8'h22);
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle();
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL wrap_pending got=%0d want=0", exp_wr.size());
      end
   endtask
   task automatic test_overflow;
      bus.wr_ready = 1'b0;
      pulse(8'h10);
      for (int i = 1; i <= 6; i++) pulse(8'(i));
      pulse(8'h00, 1'b0, 1'b1);
      checks++;
      if ({bus.wr_valid, bus.err, bus.busy} !== 3'b111) begin
         failures++;
         $display("FAIL overflow_flags got=%b%b%b want=111", bus.wr_valid, bus.err, bus.busy);
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== 16'h1001) begin
         failures++;
         $display("FAIL overflow_head got=%h_%h want=10_01", bus.wr_addr, bus.wr_data);
      end
      repeat (3) @(posedge sclk);
      #1;
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== 16'h1001) begin
         failures++;
         $display("FAIL overflow_head_stable got=%h_%h want=10_01", bus.wr_addr, bus.wr_data);
      end
      for (int i = 1; i <= 4; i++) exp_wr.push_back({8'(15 + i), 8'(i)});
      bus.wr_ready = 1'b1;
      wait_idle();
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL overflow_pending got=%0d want=0", exp_wr.size());
      end
      checks++;
      if (bus.err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky got=%b want=1", bus.err);
      end
      pulse(8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.err !== 1'b0) begin
         failures++;
         $display("FAIL err_clr got=%b want=0", bus.err);
      end
   endtask
   task automatic test_burst_limit;
      for (int i = 0; i < 16; i++) exp_wr.push_back({8'(i), 8'(8'h40 + i)});
      pulse(8'h00);
      for (int i = 0; i < 17; i++) pulse(8'(8'h40 + i));
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle();
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL burst_pending got=%0d want=0", exp_wr.size());
      end
      checks++;
      if (bus.err !== 1'b1) begin
         failures++;
         $display("FAIL burst_err got=%b want=1", bus.err);
      end
      pulse(8'h00, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic test_bad_addr;
      pulse(8'h50);
      checks++;
      if ({bus.err, bus.busy} !== 2'b11) begin
         failures++;
         $display("FAIL bad_addr_flags got=%b%b want=11", bus.err, bus.busy);
      end
      pulse(8'h12);
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle();
      pulse(8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.err !== 1'b0) begin
         failures++;
         $display("FAIL bad_addr_clr got=%b want=0", bus.err);
      end
      pulse(8'h7F, 1'b1, 1'b0, 1'b1);
      checks++;
      if (bus.err !== 1'b1) begin
         failures++;
         $display("FAIL err_set_wins got=%b want=1", bus.err);
      end
      pulse(8'h00, 1'b0, 1'b1, 1'b1);
   endtask
   task automatic test_frame_end_same_cycle;
      exp_wr.push_back(16'h3077);
      exp_wr.push_back(16'h3266);
      pulse(8'h30);
      pulse(8'h77, 1'b1, 1'b1);
      pulse(8'h05, 1'b1, 1'b1);
      wait_idle();
      pulse(8'h32);
      pulse(8'h66);
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle();
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL same_cycle_pending got=%0d want=0", exp_wr.size());
      end
   endtask
   task automatic test_reset_drain;
      bus.wr_ready = 1'b0;
      pulse(8'h20);
      pulse(8'h01);
      pulse(8'h02);
      pulse(8'h03);
      pulse(8'h00, 1'b0, 1'b1);
      checks++;
      if (bus.wr_valid !== 1'b1) begin
         failures++;
         $display("FAIL drain_queued got=%b want=1", bus.wr_valid);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({bus.wr_valid, bus.busy} !== 2'b00) begin
         failures++;
         $display("FAIL async_reset got=%b%b want=00", bus.wr_valid, bus.busy);
      end
      @(posedge sclk); #1;
      rstn = 1'b1;
      bus.wr_ready = 1'b1;
      repeat (5) @(posedge sclk);
      #1;
      checks++;
      if (bus.wr_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_valid got=%b want=0", bus.wr_valid);
      end
      exp_wr.push_back(16'h0799);
      pulse(8'h07);
      pulse(8'h99);
      pulse(8'h00, 1'b0, 1'b1);
      wait_idle();
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL post_reset_pending got=%0d want=0", exp_wr.size());
      end
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      bus.frame_end  = 1'b0;
      bus.wr_ready   = 1'b0;
      bus.err_clr    = 1'b0;
      test_reset();
      test_write_burst();
      test_read();
      test_wrap();
      test_overflow();
      test_burst_limit();
      test_bad_addr();
      test_frame_end_same_cycle();
      test_reset_drain();
      checks++;
      if (exp_wr.size() + exp_rd.size() != 0) begin
         failures++;
         $display("FAIL final_pending got=%0d want=0", exp_wr.size() + exp_rd.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
